// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding imem request FSM feeding a small FIFO to decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect raises sticky fetch_err_o and halts fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        incr_pc_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] d_inst_o,
    output logic [31:0] d_pc_o,
    output logic        d_valid_o,
    output logic        fetch_err_o
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic [31:0]        buf_pc_q   [BUF_DEPTH];
    logic [31:0]        buf_inst_q [BUF_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        redir_target;
    logic               halt;
    logic               grant, push, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic err_q;

    assign redir_target = redirect_pc_i;
    assign halt         = err_q;
    assign fetch_err_o  = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc_i[1:0];
    assign redir_target  = {redirect_pc_i[31:2], 2'b00};
    assign halt          = 1'b0;
    assign fetch_err_o   = 1'b0;
`endif

    // In S_REQ nothing is outstanding, so the credit check reduces to the buffer count.
    always_comb begin
        imem_req_o  = !rst_i && (state_q == S_REQ) && !halt && (count_q < CNT_W'(BUF_DEPTH));
        imem_addr_o = pc_q;
        d_valid_o   = !rst_i && (count_q != '0);
        d_inst_o    = d_valid_o ? buf_inst_q[rd_ptr_q] : NOP;
        d_pc_o      = d_valid_o ? buf_pc_q[rd_ptr_q] : 32'h0;
        grant       = imem_req_o && imem_gnt_i;
        push        = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;
        pop         = d_valid_o && incr_pc_i && !redirect_i;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        unique case (state_q)
            S_REQ: begin
                if (grant) begin
                    state_d = redirect_i ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                end else if (redirect_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (grant) begin
            req_pc_d = pc_q;
        end
        if (redirect_i) begin
            pc_d = redir_target;
        end else if (grant) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            if (redirect_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push && !pop) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]   <= req_pc_q;
            buf_inst_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected {pc, inst} into a scoreboard queue,
// a negedge monitor pops and compares every instruction decode consumes.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_i, incr_pc_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] d_inst_o, d_pc_o;
    logic        d_valid_o, fetch_err_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .incr_pc_i    (incr_pc_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .d_inst_o     (d_inst_o),
        .d_pc_o       (d_pc_o),
        .d_valid_o    (d_valid_o),
        .fetch_err_o  (fetch_err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    // Monitor: every consumed instruction must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i && d_valid_o && incr_pc_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h inst %h expected none", d_pc_o, d_inst_o);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", d_pc_o, e.pc);
                chk("sb_inst", d_inst_o, e.inst);
            end
            pops++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; incr_pc_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        next();
        @(negedge clk);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(d_valid_o), 32'd0);
        chk("rst_inst", d_inst_o, 32'h0000_0013);
        chk("rst_pc", d_pc_o, 32'h0);
        chk("rst_err", 32'(fetch_err_o), 32'd0);
        next();
        rst_i = 1'b0;

        // Always-grant/always-valid memory, decode stalled to fill the buffer.
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093;
        expect_inst(32'h0, 32'h0050_0093);
        expect_inst(32'h4, 32'h0050_0093);
        expect_inst(32'h8, 32'h0050_0093);
        @(negedge clk);
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        next();
        next();
        @(negedge clk);
        chk("lat_valid", 32'(d_valid_o), 32'd1);
        chk("lat_pc", d_pc_o, 32'h0);
        chk("lat_inst", d_inst_o, 32'h0050_0093);
        repeat (9) next();
        @(negedge clk);
        chk("full_req", 32'(imem_req_o), 32'd0);
        chk("full_head_pc", d_pc_o, 32'h0);
        next();
        incr_pc_i = 1'b1;
        for (int i = 0; i < 20 && pops < 3; i++) next();
        chk("drain_pops", 32'(pops), 32'd3);

        // Reset mid-transaction, then a late response that must be ignored.
        incr_pc_i = 1'b0; rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("rst2_req", 32'(imem_req_o), 32'd0);
        next();
        rst_i = 1'b0; incr_pc_i = 1'b1;
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0001;
        next();
        imem_gnt_i = 1'b0; imem_rdata_i = 32'h1111_1111;
        expect_inst(32'h0, 32'h1111_1111);
        next();
        imem_rvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_req", 32'(imem_req_o), 32'd1);
            chk("stall_addr", imem_addr_o, 32'h4);
            next();
        end
        imem_gnt_i = 1'b1;
        next();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2222_2222;
        expect_inst(32'h4, 32'h2222_2222);
        next();

        // Redirect while waiting; stale response arrives three cycles later.
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        next();
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
        next();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("drop_req", 32'(imem_req_o), 32'd0);
        chk("drop_valid", 32'(d_valid_o), 32'd0);
        next();
        next();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        next();
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        expect_inst(32'h100, 32'h3333_3333);
        @(negedge clk);
        chk("redir_req", 32'(imem_req_o), 32'd1);
        chk("redir_addr", imem_addr_o, 32'h100);
        next();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333_3333;
        next();

        // Redirect coinciding with rvalid: data dropped.
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        next();
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h200;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h4444_4444;
        next();
        redirect_i = 1'b0; imem_rvalid_i = 1'b0; incr_pc_i = 1'b0;
        @(negedge clk);
        chk("same_req", 32'(imem_req_o), 32'd1);
        chk("same_addr", imem_addr_o, 32'h200);
        chk("same_valid", 32'(d_valid_o), 32'd0);
        imem_gnt_i = 1'b1;
        next();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5555_5555;
        next();

        // Redirect with a granted request and a non-empty buffer: flush and drop.
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
        @(negedge clk);
        chk("flush_pre_valid", 32'(d_valid_o), 32'd1);
        chk("flush_pre_pc", d_pc_o, 32'h200);
        chk("flush_pre_inst", d_inst_o, 32'h5555_5555);
        chk("flush_pre_addr", imem_addr_o, 32'h204);
        next();
        imem_gnt_i = 1'b0; redirect_i = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(d_valid_o), 32'd0);
        chk("flush_req", 32'(imem_req_o), 32'd0);
        next();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h6666_6666;
        next();
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("stale_req", 32'(imem_req_o), 32'd1);
        chk("stale_addr", imem_addr_o, 32'h300);
        chk("stale_valid", 32'(d_valid_o), 32'd0);
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        next();

        // Retarget without grant, then PC wrap-around.
        redirect_i = 1'b0;
        @(negedge clk);
        chk("retarget_addr", imem_addr_o, 32'hFFFF_FFFC);
        imem_gnt_i = 1'b1;
        next();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h9999_9999; incr_pc_i = 1'b1;
        expect_inst(32'hFFFF_FFFC, 32'h9999_9999);
        next();
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("wrap_req", 32'(imem_req_o), 32'd1);
        chk("wrap_addr", imem_addr_o, 32'h0);
        imem_gnt_i = 1'b1;
        next();

        // Misaligned redirect while waiting.
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h102;
        next();
        redirect_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h7777_7777;
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misalign_err", 32'(fetch_err_o), 32'd1);
`else
        chk("misalign_err", 32'(fetch_err_o), 32'd0);
`endif
        next();
        imem_rvalid_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        imem_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_req", 32'(imem_req_o), 32'd0);
            chk("halt_err", 32'(fetch_err_o), 32'd1);
            next();
        end
        imem_gnt_i = 1'b0;
`else
        @(negedge clk);
        chk("align_req", 32'(imem_req_o), 32'd1);
        chk("align_addr", imem_addr_o, 32'h100);
        imem_gnt_i = 1'b1;
        expect_inst(32'h100, 32'h8888_8888);
        next();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h8888_8888;
        next();
        imem_rvalid_i = 1'b0;
        next();
        next();
`endif
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; legal values 2 or 4.
REQ-003 Port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_i  input  1  reset, synchronous and active-high.
REQ-005 Port incr_pc_i  input  1  decode consumes d_inst_o this cycle when d_valid_o=1.
REQ-006 Port redirect_i  input  1  taken branch/jump; flush and refetch.
REQ-007 Port redirect_pc_i  input  32  redirect target.
REQ-008 Port imem_req_o  output  1  instruction memory request.
REQ-009 Port imem_addr_o  output  32  request address.
REQ-010 Port imem_gnt_i  input  1  request accepted this cycle.
REQ-011 Port imem_rvalid_i  input  1  read data valid.
REQ-012 Port imem_rdata_i  input  32  read data.
REQ-013 Port d_inst_o  output  32  instruction to decode.
REQ-014 Port d_pc_o  output  32  PC of d_inst_o.
REQ-015 Port d_valid_o  output  1  d_inst_o/d_pc_o valid.
REQ-016 Port fetch_err_o  output  1  sticky misaligned-redirect flag.

Function
REQ-017 FSM states SHALL be S_REQ (imem_req_o=1), S_WAIT (one request outstanding), S_DROP (outstanding response to discard).
REQ-018 Single outstanding request at most; S_REQ asserts imem_req_o only when buffer count + outstanding < BUF_DEPTH, else imem_req_o=0 and remain in S_REQ.
REQ-019 imem_addr_o SHALL equal fetch PC register and stay stable while imem_req_o=1 and imem_gnt_i=0, except on redirect.
REQ-020 S_REQ with imem_req_o=1 and imem_gnt_i=1 -> S_WAIT; fetch PC += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-021 S_WAIT with imem_rvalid_i=1 -> push {PC of request, imem_rdata_i} into buffer, -> S_REQ; same-cycle new request not issued (one bubble cycle).
REQ-022 Buffer FIFO: head drives d_inst_o/d_pc_o; d_valid_o=1 iff non-empty; pop when d_valid_o & incr_pc_i; push and pop in same cycle allowed, count unchanged.
REQ-023 Empty buffer: d_inst_o=32'h0000_0013 (NOP), d_pc_o=0, d_valid_o=0; incr_pc_i ignored.
REQ-024 Overflow impossible by REQ-018; push into full buffer SHALL never occur.
REQ-025 redirect_i=1: buffer flushed (no pop counted), fetch PC <= redirect_pc_i, next state S_REQ; d_valid_o=0 next cycle.
REQ-026 redirect_i in S_WAIT without imem_rvalid_i -> S_DROP; next imem_rvalid_i discarded, then -> S_REQ.
REQ-027 redirect_i in S_WAIT with imem_rvalid_i same cycle -> data discarded, -> S_REQ.
REQ-028 redirect_i in S_REQ with imem_gnt_i same cycle -> granted request becomes stale, -> S_DROP.
REQ-029 redirect_i in S_REQ without grant -> imem_addr_o retargets to redirect_pc_i next cycle.
REQ-030 Redirect in S_DROP: stays S_DROP, fetch PC updated; only one response discarded.
REQ-031 Latency: gnt cycle N, rvalid N+1 -> d_valid_o=1 at N+2.

Reset
REQ-032 rst_i=1 at rising edge: state S_REQ, fetch PC=RESET_PC, buffer empty, fetch_err_o=0; outstanding request forgotten.
REQ-033 Outputs during/after reset cycle: imem_req_o=0 while rst_i=1; d_valid_o=0; d_inst_o=32'h0000_0013; d_pc_o=0.
REQ-034 imem_req_o=1 with imem_addr_o=RESET_PC in first cycle rst_i=0.
REQ-035 Reset mid-transaction: late imem_rvalid_i after reset with no request issued SHALL be ignored.

Configuration
REQ-036 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc_i[1:0]!=0 sets fetch_err_o (sticky until reset), halts fetch (imem_req_o=0) and drains buffer normally.
REQ-037 Macro undefined: redirect_pc_i[1:0] forced to 0, fetch_err_o tied 0.

Verification
REQ-038 Reset release, gnt and rvalid always 1, rdata=32'h0050_0093 -> req at 0x0, d_valid_o=1 with d_pc_o=0x0, d_inst_o=32'h0050_0093 two cycles after first grant.
REQ-039 incr_pc_i=0 for 10 cycles -> exactly BUF_DEPTH entries buffered, imem_req_o=0 thereafter; resume -> PCs 0x0,0x4,0x8 in order, none lost.
REQ-040 imem_gnt_i held 0 for 5 cycles -> imem_addr_o stable at 0x4 throughout.
REQ-041 redirect_i to 0x100 while S_WAIT, rvalid returns 3 cycles later with 0xDEADBEEF -> 0xDEADBEEF never presented; next d_pc_o=0x100.
REQ-042 redirect_i and imem_rvalid_i same cycle -> data dropped, next imem_addr_o=redirect target.
REQ-043 FETCH_MISALIGN_CHECK_EN defined, redirect to 0x102 -> fetch_err_o=1 next cycle, no further requests; undefined -> fetch from 0x100.
